// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU word/byte memory with a background DMA block-copy engine.
// Define MEM_CTRL_DMA_EN to build the DMA engine; otherwise DMA commands are no-ops.
module mem_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] DMA_CAUSE = 32'd9
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        INTin,
  output logic [31:0] INTnum,
  output logic        dma_busy
);
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] word, dma_addr;
  logic [31:0] dma_data;
  logic dma_wr, stall, unused;
  assign word = Addr[ADDR_W+1:2];
  // any CPU access owns the memory this cycle; the DMA engine waits
  assign stall = Memread || Memwrite != 2'd0;
  assign BUS = (Memread && Memwrite == 2'd0) ? mem[word] >> {Addr[1:0], 3'b000} : 32'bz;
  always_ff @(posedge clk)
    if (Memwrite == 2'd1) mem[word] <= BUS;
    else if (Memwrite == 2'd3) mem[word][{Addr[1:0], 3'b000} +: 8] <= BUS[7:0];
    else if (dma_wr) mem[dma_addr] <= dma_data;
`ifdef MEM_CTRL_DMA_EN
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] src, dst;
  logic [15:0] len;
  logic [31:0] data_buf;
  assign dma_wr = state == WR && !stall && !rst;
  assign dma_addr = dst;
  assign dma_data = data_buf;
  assign unused = ^{Addr[31:ADDR_W+2]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      data_buf <= '0;
      INTin <= 1'b0;
      INTnum <= '0;
      dma_busy <= 1'b0;
    end else
      case (state)
        IDLE: if (Memwrite == 2'd2) begin
          src <= word;
          dst <= BUS[ADDR_W+15:16];
          len <= BUS[15:0];
          state <= BUS[15:0] == 16'd0 ? DONE : RD;
          dma_busy <= BUS[15:0] != 16'd0;
          INTin <= BUS[15:0] == 16'd0;
          INTnum <= BUS[15:0] == 16'd0 ? DMA_CAUSE : INTnum;
        end
        RD: if (!stall) begin
          data_buf <= mem[src];
          state <= WR;
        end
        WR: if (!stall) begin
          src <= src + 1'b1;
          dst <= dst + 1'b1;
          len <= len - 1'b1;
          state <= len == 16'd1 ? DONE : RD;
          dma_busy <= len != 16'd1;
          INTin <= len == 16'd1;
          INTnum <= len == 16'd1 ? DMA_CAUSE : INTnum;
        end
        DONE: begin
          INTin <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  end
`else
  assign dma_wr = 1'b0;
  assign dma_addr = '0;
  assign dma_data = '0;
  assign INTin = 1'b0;
  assign INTnum = '0;
  assign dma_busy = 1'b0;
  assign unused = ^{Addr[31:ADDR_W+2], rst};
`endif
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller on the CPU's downstream side. Owns the CPU's data/instruction memory. Serves single-cycle word reads and word/byte writes from the CPU's `BUS`/`Addr`/`Memread`/`Memwrite` pins. Runs a background DMA block-copy engine, started by a `Memwrite` DMA command, that signals completion back to the CPU's `INTin`/`INTnum` pins.

## Interface
- `ADDR_W`, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
- `DMA_CAUSE`, 32'd9, value driven on `INTnum` on DMA completion.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, synchronous, active-high.
- `BUS`  inout  32  shared data bus; driven by this block only during reads.
- `Memread`  in  1  read request for the current cycle.
- `Memwrite`  in  2  0: none, 1: word write, 2: DMA command, 3: byte write.
- `Addr`  in  32  byte address; word index = `Addr[ADDR_W+1:2]`, upper bits ignored (aliasing).
- `INTin`  out  1  one-cycle DMA-done pulse to the CPU.
- `INTnum`  out  32  interrupt cause accompanying `INTin`.
- `dma_busy`  out  1  DMA transfer in progress.

## Operation
- Read (`Memread`=1, `Memwrite`=0):
  - Combinational.
  - `BUS` = `mem[word] >> (8*Addr[1:0])`; aligned word reads return the full word, byte loads find their byte in `BUS[7:0]`.
  - `BUS` is high-Z otherwise.
- Word write (`Memwrite`=1): `mem[word] <= BUS` at the rising edge.
- Byte write (`Memwrite`=3): byte lane `Addr[1:0]` of `mem[word]` <= `BUS[7:0]`; the other lanes are unchanged.
- `Memread` together with nonzero `Memwrite`: the write executes and `BUS` is not driven.
- DMA command (`Memwrite`=2, engine IDLE):
  - Latch `src` = `Addr[ADDR_W+1:2]`, `dst` = `BUS[ADDR_W-1+16:16]` (word index), `len` = `BUS[15:0]`.
  - Command while not IDLE: ignored, no state change.
- DMA FSM states, with `dma_busy`=1 in RD and WR:
  - IDLE: on command, go to RD, or to DONE if `len`=0.
  - RD: `buf <= mem[src]`, go to WR.
  - WR: `mem[dst] <= buf`; increment `src` and `dst` modulo 2^ADDR_W; decrement `len`; go to DONE if `len` was 1, else RD.
  - DONE: `INTin`=1 for exactly this cycle, `INTnum` <= `DMA_CAUSE`; go to IDLE.
- Contention:
  - Any cycle with `Memread`=1 or `Memwrite`≠0 stalls RD/WR; the FSM holds its state and registers.
  - CPU access always wins, because the CPU has no wait input.
- Copy order is ascending. Overlapping ranges with `dst` > `src` therefore propagate data; this is defined behaviour, not an error.
- `INTnum` holds `DMA_CAUSE` after the first completion until reset.

## Timing
- Read latency: data valid on `BUS` in the same cycle `Memread` is high, before the next rising edge where the CPU samples it.
- Write visibility: a write at edge k is readable in the cycle after edge k. No read-during-write forwarding is needed, since read and write never share a cycle.
- DMA throughput: 2 cycles per word uncontested. Total latency from command edge to `INTin` = 2·len + 1 cycles (1 cycle for len=0), plus one cycle per stalled cycle.
- Reset values: `INTin`=0, `INTnum`=0, `dma_busy`=0, FSM=IDLE, `src`/`dst`/`len`/`buf`=0, `BUS` high-Z.
- Memory contents are not cleared by reset.
- Reset mid-DMA: the transfer aborts immediately. Words already written stay written, and no `INTin` pulse is produced.

## Configuration
- `MEM_CTRL_DMA_EN` defined: the DMA engine is built as described.
- Not defined:
  - FSM, `buf`, `src`, `dst` and `len` are omitted.
  - `Memwrite`=2 is a no-op.
  - `INTin`, `INTnum` and `dma_busy` are tied to 0.
  - Read/write behaviour is unchanged.

## Test plan
- Word write then read: write 0xDEADBEEF at Addr 0x40, read Addr 0x40 next cycle -> `BUS`=0xDEADBEEF; `BUS` high-Z in idle cycles.
- Byte write/read:
  - Stimulus: word 0x11223344 at 0x40; byte write 0xAA at 0x42.
  - Word read 0x40 -> 0x11AA3344.
  - Read 0x42 -> `BUS[7:0]`=0xAA.
- DMA copy:
  - Stimulus: words 1..4 at word index 16..19; command `Addr`=0x40, `BUS`=0x0020_0004.
  - `dma_busy` high 8 cycles; `INTin` pulses on cycle 9 with `INTnum`=9.
  - Word index 32..35 = 1..4.
- Stall and len=0:
  - CPU reads on 3 cycles during a 2-word DMA -> `INTin` at cycle 5+3=8.
  - Command with `len`=0 -> `INTin` the next cycle, memory unchanged.
- Busy/reset:
  - Second command during busy is ignored; the original destination completes.
  - `rst` asserted mid-transfer -> `dma_busy`=0 next cycle, no `INTin`, partial copy retained.
- Without `MEM_CTRL_DMA_EN`: DMA command -> memory unchanged, `INTin` stays 0.
